// File: rtl/bn_avg_sched.sv
// Mean scheduler for the batch-norm path. It lets CH requesters share one
// combinational FP16 adder and one FP16 multiplier. It serially sums a
// SIZE-element vector and then scales the sum by RECIP (1/SIZE).
module bn_avg_sched #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           SIZE       = 4,
  parameter int unsigned           CH         = 2,
  parameter logic [DATA_WIDTH-1:0] RECIP      = 16'h3400
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [CH-1:0]                            req,
  input  logic [CH*SIZE*DATA_WIDTH-1:0]            vec_in,
  output logic [CH-1:0]                            grant,
  output logic [DATA_WIDTH-1:0]                    fadd_a,
  output logic [DATA_WIDTH-1:0]                    fadd_b,
  input  logic [DATA_WIDTH-1:0]                    fadd_sum,
  output logic [DATA_WIDTH-1:0]                    fmul_a,
  output logic [DATA_WIDTH-1:0]                    fmul_b,
  input  logic [DATA_WIDTH-1:0]                    fmul_p,
  output logic [DATA_WIDTH-1:0]                    avg_out,
  output logic [((CH > 1) ? $clog2(CH) : 1)-1:0]   avg_ch,
  output logic                                     avg_valid,
  output logic                                     busy
);

  localparam int unsigned ChW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned CntW = $clog2(SIZE + 1);
  localparam int unsigned VecW = SIZE * DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StAcc, StScale} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [VecW-1:0]       vec_q, vec_d;
  logic [ChW-1:0]        ch_q, ch_d;
  logic [ChW-1:0]        rr_q, rr_d;
  logic [CH-1:0]         grant_q, grant_d;
  logic [DATA_WIDTH-1:0] avg_q, avg_d;
  logic [ChW-1:0]        avg_ch_q, avg_ch_d;
  logic                  valid_q, valid_d;

  logic                  win_found;
  logic [ChW-1:0]        win_idx;
  logic [VecW-1:0]       win_vec;

  // Round-robin pick: first set req bit searching upward from rr_q+1, wrapping at CH.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int off = 1; off <= int'(CH); off++) begin
      for (int c = 0; c < int'(CH); c++) begin
        if (!win_found && req[c] && (c == ((int'(rr_q) + off) % int'(CH)))) begin
          win_found = 1'b1;
          win_idx   = ChW'(c);
        end
      end
    end
  end

  // Mux out the winning channel's vector.
  always_comb begin
    win_vec = '0;
    for (int c = 0; c < int'(CH); c++) begin
      if (ChW'(c) == win_idx) begin
        win_vec = vec_in[c*VecW +: VecW];
      end
    end
  end

  // Next-state logic for the IDLE -> ACC -> SCALE job sequence.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    vec_d    = vec_q;
    ch_d     = ch_q;
    rr_d     = rr_q;
    grant_d  = '0;
    avg_d    = avg_q;
    avg_ch_d = avg_ch_q;
    valid_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (win_found) begin
          vec_d   = win_vec;
          ch_d    = win_idx;
          rr_d    = win_idx;
          acc_d   = '0;
          cnt_d   = '0;
          grant_d = CH'(1) << win_idx;
          state_d = StAcc;
        end
      end
      StAcc: begin
        acc_d = fadd_sum;
        cnt_d = cnt_q + 1'b1;
        // Shift the latched vector so the current element always sits in the low word.
        vec_d = vec_q >> DATA_WIDTH;
        if (cnt_q == CntW'(SIZE - 1)) begin
          state_d = StScale;
        end
      end
      StScale: begin
        avg_d    = fmul_p;
        avg_ch_d = ch_q;
        valid_d  = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register. rr_q resets to CH-1 so channel 0 wins the first arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      cnt_q    <= '0;
      vec_q    <= '0;
      ch_q     <= '0;
      rr_q     <= ChW'(CH - 1);
      grant_q  <= '0;
      avg_q    <= '0;
      avg_ch_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      vec_q    <= vec_d;
      ch_q     <= ch_d;
      rr_q     <= rr_d;
      grant_q  <= grant_d;
      avg_q    <= avg_d;
      avg_ch_q <= avg_ch_d;
      valid_q  <= valid_d;
    end
  end

  // Operand drive to the shared FP units. Operands are held at zero while a unit is unused.
  always_comb begin
    fadd_a = '0;
    fadd_b = '0;
    fmul_a = '0;
    fmul_b = '0;
    if (state_q == StAcc) begin
      fadd_a = vec_q[DATA_WIDTH-1:0];
      fadd_b = acc_q;
    end
    if (state_q == StScale) begin
      fmul_a = acc_q;
      fmul_b = RECIP;
    end
  end

  assign grant     = grant_q;
  assign avg_out   = avg_q;
  assign avg_ch    = avg_ch_q;
  assign avg_valid = valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bn_avg_sched.sv
// Bench for bn_avg_sched. It uses real-valued FP16 models of the shared
// adder and multiplier, and a job-level reference model of arbitration and timing.
module tb_bn_avg_sched;

  localparam int          DW    = 16;
  localparam int          SIZE  = 4;
  localparam int          CH    = 2;
  localparam logic [15:0] RECIP = 16'h3400;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [CH-1:0]          req;
  logic [CH*SIZE*DW-1:0]  vec_in;
  logic [CH-1:0]          grant;
  logic [DW-1:0]          fadd_a, fadd_b, fadd_sum;
  logic [DW-1:0]          fmul_a, fmul_b, fmul_p;
  logic [DW-1:0]          avg_out;
  logic [0:0]             avg_ch;
  logic                   avg_valid;
  logic                   busy;

  logic [DW-1:0]          vecs [CH][SIZE];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  bn_avg_sched #(
    .DATA_WIDTH(DW),
    .SIZE      (SIZE),
    .CH        (CH),
    .RECIP     (RECIP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .vec_in   (vec_in),
    .grant    (grant),
    .fadd_a   (fadd_a),
    .fadd_b   (fadd_b),
    .fadd_sum (fadd_sum),
    .fmul_a   (fmul_a),
    .fmul_b   (fmul_b),
    .fmul_p   (fmul_p),
    .avg_out  (avg_out),
    .avg_ch   (avg_ch),
    .avg_valid(avg_valid),
    .busy     (busy)
  );

  function automatic real fp2r(input logic [15:0] h);
    int  e;
    real v;
    e = int'(h[14:10]);
    if (e == 0) begin
      v = real'(h[9:0]) / 16777216.0;
    end else begin
      v = 1.0 + real'(h[9:0]) / 1024.0;
      while (e > 15) begin v = v * 2.0; e--; end
      while (e < 15) begin v = v / 2.0; e++; end
    end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2fp(input real r);
    real  a;
    int   e;
    int   m;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = $rtoi((a - 1.0) * 1024.0 + 0.5);
    if (m == 1024) begin m = 0; e++; end
    return {s, e[4:0], m[9:0]};
  endfunction

  // Behavioural stand-ins for the external floatAdd / floatMult instances.
  always_comb fadd_sum = r2fp(fp2r(fadd_a) + fp2r(fadd_b));
  always_comb fmul_p   = r2fp(fp2r(fmul_a) * fp2r(fmul_b));

  always_comb begin
    vec_in = '0;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < SIZE; k++)
        vec_in[(c*SIZE+k)*DW +: DW] = vecs[c][k];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: one job at a time; a job decided in cycle d grants in d+1,
  // adds in d+1..d+SIZE, scales in d+SIZE+1 and reports in d+SIZE+2.
  int          m_rr;
  int          m_dec;
  int          m_free;
  bit          m_job;
  int          m_ch;
  logic [15:0] m_vec [SIZE];
  logic [15:0] m_hold_avg;
  int          m_hold_ch;
  bit          g1_seen;

  task automatic model_reset();
    m_job      = 0;
    m_rr       = CH - 1;
    m_dec      = -100;
    m_free     = 0;
    m_hold_avg = 16'h0000;
    m_hold_ch  = 0;
  endtask

  task automatic model_decide();
    bit          found;
    int          win;
    logic [31:0] rq;
    found = 0;
    win   = 0;
    rq    = 32'(req);
    if (cyc >= m_free && req != '0) begin
      for (int off = 1; off <= CH; off++) begin
        int c;
        c = (m_rr + off) % CH;
        if (!found && ((rq >> c) & 32'd1) != 0) begin
          found = 1;
          win   = c;
        end
      end
      m_dec  = cyc;
      m_free = cyc + SIZE + 2;
      m_rr   = win;
      m_ch   = win;
      m_vec  = vecs[win];
      m_job  = 1;
    end
  endtask

  task automatic check_cycle();
    int          rel;
    logic [31:0] e_grant, e_fa, e_fb, e_ma, e_mb;
    bit          e_busy, e_valid;
    real         s, tot;
    rel     = m_job ? (cyc - m_dec) : -1;
    e_grant = 0; e_fa = 0; e_fb = 0; e_ma = 0; e_mb = 0;
    e_busy  = 0; e_valid = 0;
    tot     = 0.0;
    for (int j = 0; j < SIZE; j++) tot += fp2r(m_vec[j]);
    if (rel == 1) e_grant = 32'(1 << m_ch);
    if (rel >= 1 && rel <= SIZE + 1) e_busy = 1;
    if (rel >= 1 && rel <= SIZE) begin
      s = 0.0;
      for (int j = 0; j < rel - 1; j++) s += fp2r(m_vec[j]);
      e_fa = 32'(m_vec[rel-1]);
      e_fb = 32'(r2fp(s));
    end
    if (rel == SIZE + 1) begin
      e_ma = 32'(r2fp(tot));
      e_mb = 32'(RECIP);
    end
    if (rel == SIZE + 2) begin
      e_valid    = 1;
      m_hold_avg = r2fp(tot * fp2r(RECIP));
      m_hold_ch  = m_ch;
    end
    if (grant[1]) g1_seen = 1;
    chk("grant", 32'(grant), e_grant);
    chk("busy", 32'(busy), 32'(e_busy));
    chk("avg_valid", 32'(avg_valid), 32'(e_valid));
    chk("fadd_a", 32'(fadd_a), e_fa);
    chk("fadd_b", 32'(fadd_b), e_fb);
    chk("fmul_a", 32'(fmul_a), e_ma);
    chk("fmul_b", 32'(fmul_b), e_mb);
    chk("avg_out", 32'(avg_out), 32'(m_hold_avg));
    chk("avg_ch", 32'(avg_ch), 32'(m_hold_ch));
  endtask

  task automatic step();
    model_decide();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic rand_vec(input int c);
    for (int k = 0; k < SIZE; k++)
      vecs[c][k] = r2fp(real'($urandom_range(0, 16)) - 8.0);
  endtask

  initial begin
    int          t0;
    logic [15:0] fb_tab [4];
    fb_tab[0] = 16'h0000; fb_tab[1] = 16'h3C00; fb_tab[2] = 16'h4200; fb_tab[3] = 16'h4600;
    reset = 1'b0;
    req   = '0;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < SIZE; k++) vecs[c][k] = 16'h0000;
    model_reset();
    g1_seen = 0;
    run(2);
    reset = 1'b1;
    run(1);

    // Both channels requesting continuously: grants alternate starting at ch0.
    for (int k = 0; k < SIZE; k++) begin vecs[0][k] = 16'h4400; vecs[1][k] = 16'h4800; end
    req = 2'b11;
    t0  = cyc;
    run_to(t0 + 1);  chk("alt_g1", 32'(grant), 32'h1);
    run_to(t0 + 6);  chk("alt_avg1", 32'(avg_out), 32'h4400); chk("alt_ch1", 32'(avg_ch), 0);
    run_to(t0 + 7);  chk("alt_g2", 32'(grant), 32'h2);
    run_to(t0 + 12); chk("alt_avg2", 32'(avg_out), 32'h4800); chk("alt_ch2", 32'(avg_ch), 1);
    run_to(t0 + 13); chk("alt_g3", 32'(grant), 32'h1);
    req = '0;
    run_to(t0 + 20);

    // Single ch0 job with the 1,2,3,4 vector.
    vecs[0][0] = 16'h3C00; vecs[0][1] = 16'h4000; vecs[0][2] = 16'h4200; vecs[0][3] = 16'h4400;
    req = 2'b01;
    t0  = cyc;
    run_to(t0 + 1);
    chk("one_grant", 32'(grant), 32'h1);
    req = '0;
    for (int k = 1; k <= 4; k++) begin
      run_to(t0 + k);
      chk("one_fadd_b", 32'(fadd_b), 32'(fb_tab[k-1]));
    end
    run_to(t0 + 6);
    chk("one_valid", 32'(avg_valid), 1);
    chk("one_avg", 32'(avg_out), 32'h4100);
    chk("one_ch", 32'(avg_ch), 0);
    run(2);

    // Fairness: ch1 served last, then both request -> ch0 wins.
    rand_vec(1);
    req = 2'b10;
    t0  = cyc;
    run_to(t0 + 1);  chk("fair_g1", 32'(grant), 32'h2);
    req = '0;
    run_to(t0 + 6);
    rand_vec(0);
    req = 2'b11;
    t0  = cyc;
    run_to(t0 + 1);  chk("fair_g0", 32'(grant), 32'h1);
    req = '0;
    run(8);

    // Reset in the middle of accumulation abandons the job.
    rand_vec(0);
    req = 2'b01;
    t0  = cyc;
    run_to(t0 + 1);
    req = '0;
    run_to(t0 + 3);
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    chk("rst_fadd_b", 32'(fadd_b), 0);
    chk("rst_avg", 32'(avg_out), 0);
    chk("rst_valid", 32'(avg_valid), 0);
    run(2);
    reset = 1'b1;
    rand_vec(1);
    req = 2'b10;
    t0  = cyc;
    run_to(t0 + 1);  chk("rst_new_grant", 32'(grant), 32'h2);
    req = '0;
    run_to(t0 + 6);  chk("rst_new_valid", 32'(avg_valid), 1);
    run(2);

    // Signed values cancelling to zero.
    vecs[0][0] = 16'hBC00; vecs[0][1] = 16'h3C00; vecs[0][2] = 16'hC000; vecs[0][3] = 16'h4000;
    req = 2'b01;
    t0  = cyc;
    run_to(t0 + 1);
    req = '0;
    run_to(t0 + 6);
    chk("zero_valid", 32'(avg_valid), 1);
    chk("zero_avg", 32'(avg_out), 32'h0000);
    run(2);

    // ch1 raises and drops req while ch0's job is busy: it is never granted.
    g1_seen = 0;
    rand_vec(0);
    req = 2'b01;
    t0  = cyc;
    run_to(t0 + 1);
    req = 2'b10;
    run_to(t0 + 3);
    req = '0;
    run_to(t0 + 9);
    chk("drop_no_grant", 32'(g1_seen), 0);
    chk("drop_idle", 32'(busy), 0);

    // Random requests and vectors against the reference model.
    for (int i = 0; i < 300; i++) begin
      req = CH'($urandom_range(0, 3));
      for (int c = 0; c < CH; c++) rand_vec(c);
      step();
    end
    req = '0;
    run(SIZE + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
